// File: rtl/cpu_cmd_sequencer.sv
// Command-issue front end for the CPU datapath: a small bundle FIFO feeding a
// one-command-at-a-time issue/complete/result sequencer with a completion timeout.
module cpu_cmd_sequencer #(
    parameter int         WIDTH   = 8,
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 64,
    parameter logic [6:0] NOP_CMD = 7'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_cmd,
    input  logic [WIDTH-1:0]         in_d1,
    input  logic [WIDTH-1:0]         in_d2,
    input  logic [WIDTH-1:0]         in_d3,
    input  logic [WIDTH-1:0]         in_d4,
    output logic [6:0]               cmd_out,
    output logic [WIDTH-1:0]         dout_1,
    output logic [WIDTH-1:0]         dout_2,
    output logic [WIDTH-1:0]         dout_3,
    output logic [WIDTH-1:0]         dout_4,
    input  logic                     cpu_rdy,
    input  logic [2*WIDTH-1:0]       cpu_result,
    input  logic                     cpu_zero,
    input  logic                     cpu_error,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_data,
    output logic                     res_zero,
    output logic                     res_error,
    output logic                     res_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef struct packed {
        logic [6:0]       cmd;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [WIDTH-1:0] d3;
        logic [WIDTH-1:0] d4;
    } bundle_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESULT} state_t;

    bundle_t          mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    bundle_t          issue_q, issue_d;
    logic [2*WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic             res_error_q, res_error_d;
    logic             res_timeout_q, res_timeout_d;
    logic             push, pop;

    // in_ready looks only at the registered count, so a full FIFO never
    // accepts even when the head is leaving on the same edge.
    assign in_ready = count_q < (PW+1)'(DEPTH);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0) && cpu_rdy;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{cmd: in_cmd, d1: in_d1, d2: in_d2, d3: in_d3, d4: in_d4};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        issue_d       = issue_q;
        res_data_d    = res_data_q;
        res_zero_d    = res_zero_q;
        res_error_d   = res_error_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    issue_d = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                // Normal exit is checked first so a completion on the last
                // allowed cycle still reports the real result.
                if (state_q == WAIT_BUSY && !cpu_rdy) begin
                    state_d = WAIT_DONE;
                end else if (state_q == WAIT_DONE && cpu_rdy) begin
                    res_data_d    = cpu_result;
                    res_zero_d    = cpu_zero;
                    res_error_d   = cpu_error;
                    res_timeout_d = 1'b0;
                    state_d       = RESULT;
                end else if (cnt_q == TW'(TIMEOUT-1)) begin
                    res_data_d    = '0;
                    res_zero_d    = 1'b0;
                    res_error_d   = 1'b1;
                    res_timeout_d = 1'b1;
                    state_d       = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            issue_q       <= '0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_error_q   <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            issue_q       <= issue_d;
            res_data_q    <= res_data_d;
            res_zero_q    <= res_zero_d;
            res_error_q   <= res_error_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign cmd_out     = (state_q == ISSUE) ? issue_q.cmd : NOP_CMD;
    assign dout_1      = issue_q.d1;
    assign dout_2      = issue_q.d2;
    assign dout_3      = issue_q.d3;
    assign dout_4      = issue_q.d4;
    assign res_valid   = (state_q == RESULT);
    assign res_data    = res_data_q;
    assign res_zero    = res_zero_q;
    assign res_error   = res_error_q;
    assign res_timeout = res_timeout_q;
    assign busy        = (state_q != IDLE);
    assign fifo_count  = count_q;
endmodule

// File: doc/cpu_cmd_sequencer.md
Name: cpu_cmd_sequencer

Overview:
Upstream command-issue stage for the CPU datapath. Buffers host command+operand bundles in a small FIFO and issues each one to the CPU's cmd_in/din_1..din_4 inputs when cpu_rdy is high. It then tracks completion through cpu_rdy and captures out_reg3/zero/error into a single result register. The host sees valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, operand width; CPU result is 2*WIDTH
DEPTH, 4, command FIFO entries; power of 2, >=2
TIMEOUT, 64, max cycles waiting for CPU completion before forced result
NOP_CMD, 7'd0, value driven on cmd_out when not issuing

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  host command bundle valid
in_ready  output  1  FIFO can accept (count < DEPTH)
in_cmd  input  7  command for CPU
in_d1, in_d2, in_d3, in_d4  input  WIDTH each  operands
cmd_out  output  7  to CPU cmd_in
dout_1, dout_2, dout_3, dout_4  output  WIDTH each  to CPU din_1..din_4
cpu_rdy  input  1  CPU idle/done
cpu_result  input  2*WIDTH  CPU out_reg3
cpu_zero  input  1  CPU zero flag
cpu_error  input  1  CPU error flag
res_valid  output  1  result available
res_ready  input  1  host consumes result
res_data  output  2*WIDTH  captured result
res_zero, res_error, res_timeout  output  1 each  captured flags; timeout flag
busy  output  1  state != IDLE
fifo_count  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (reset=0, async): FIFO emptied (pointers/count 0), state IDLE, cmd_out=NOP_CMD, dout_*=0, res_valid=0, res_data=0, all res flags 0, busy=0, in_ready=1, timeout counter 0.
- FIFO: push on in_valid&&in_ready. in_ready=(count<DEPTH) is combinational on count only, so there is no push when full even if a pop occurs in the same cycle. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- State machine, one transition per clock edge:
  - IDLE: if count>0 and cpu_rdy=1, pop the head into the issue registers (cmd_reg, d1..d4_reg) and go to ISSUE. Otherwise stay.
  - ISSUE: cmd_out=cmd_reg for exactly this one cycle. Clear the timeout counter, then go to WAIT_BUSY.
  - WAIT_BUSY: increment the counter. cpu_rdy=0 goes to WAIT_DONE.
  - WAIT_DONE: increment the counter. On cpu_rdy=1, capture cpu_result/cpu_zero/cpu_error into res_*, set res_timeout=0, and go to RESULT.
  - Timeout: in WAIT_BUSY or WAIT_DONE, if the counter reaches TIMEOUT-1 and the normal exit condition is false, go to RESULT with res_data=0, res_zero=0, res_error=1, res_timeout=1. A normal exit in that same cycle takes priority over timeout.
  - RESULT: res_valid=1; res_* stay stable. On res_ready=1, res_valid drops next edge and the state goes to IDLE.
- cmd_out=NOP_CMD in every state except ISSUE.
- dout_* always drive the issue registers. They are updated only on pop and held stable through ISSUE..RESULT.
- Latency: FIFO empty, cpu_rdy=1, push accepted at edge N -> pop at edge N+1 -> cmd_out valid in cycle N+1..N+2. Back-to-back commands are separated by at least 4 cycles (ISSUE, WAIT_BUSY, WAIT_DONE, RESULT, then IDLE).
- FIFO pushes continue during every state.
- Reset asserted mid-operation: immediate return to reset values. The in-flight command and queued entries are discarded.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> in_ready=1, fifo_count=0, cmd_out=0, res_valid=0. No push occurs.
- Single command: push cmd=7'h05, d1..d4=3,4,5,6. cpu_rdy is 1, drops for 3 cycles, then rises with cpu_result=16'h000C, cpu_zero=0 -> cmd_out=05 for exactly one cycle, dout_1=3 held, then res_valid=1, res_data=000C, res_timeout=0. res_ready=1 returns to IDLE.
- FIFO full: with cpu_rdy=0, push 5 bundles -> first 4 accepted, in_ready=0, fifo_count=4, fifth held. Commands are issued in push order once cpu_rdy=1.
- Timeout: issue a command, keep cpu_rdy=1 and never drop it -> after 64 cycles res_valid=1, res_timeout=1, res_error=1, res_data=0.
- Result backpressure: hold res_ready=0 for 10 cycles with 2 queued commands -> no second issue, cmd_out=0, res_data stable. Release -> next command issues.
- Mid-op reset: assert reset in WAIT_DONE with 2 entries queued -> fifo_count=0, busy=0, cmd_out=0 immediately. No result is produced after deassertion.
